pov_column_timer: RTL and testbench

//  Column-trigger generator upstream of led_driver; replaces the free-running write_data divider.

---
 rtl/pov_column_timer_if.sv | 31 +++
 rtl/pov_column_timer.sv | 133 +++++++++++++
 tb/tb_pov_column_timer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pov_column_timer_if.sv
// Bundles the encoder index input and the column-strobe outputs of pov_column_timer.
// The slave modport is the timer; the master modport is its environment.
interface pov_column_timer_if #(
    parameter int unsigned COL_LOG2 = 6,
    parameter int unsigned PERIOD_W = 26
);
    logic                index_in;
    logic                write_data;
    logic [COL_LOG2-1:0] column_idx;
    logic [PERIOD_W-1:0] rev_period;
    logic                period_valid;
    logic                short_rev;

    modport slave (
        input  index_in,
        output write_data,
        output column_idx,
        output rev_period,
        output period_valid,
        output short_rev
    );

    modport master (
        output index_in,
        input  write_data,
        input  column_idx,
        input  rev_period,
        input  period_valid,
        input  short_rev
    );
endinterface

// File: rtl/pov_column_timer.sv
// Measures the rotor period from the encoder index and emits one column strobe per
// 1/2**COL_LOG2 of a revolution, phase-locked to the index.
module pov_column_timer #(
    parameter int unsigned COL_LOG2   = 6,
    parameter int unsigned PERIOD_W   = 26,
    parameter int unsigned MIN_PERIOD = 100000
) (
    input logic               sys_clk,
    input logic               rst_n,
    pov_column_timer_if.slave bus
);
    localparam int unsigned         NumCols   = 2 ** COL_LOG2;
    localparam logic [PERIOD_W-1:0] PcntMax   = '1;
    localparam logic [PERIOD_W-1:0] MinPeriod = PERIOD_W'(MIN_PERIOD);
    localparam logic [COL_LOG2:0]   EmitFull  = (COL_LOG2 + 1)'(NumCols);

    typedef enum logic [1:0] {StIdle, StAcquire, StRun} state_e;

    state_e              r_state, w_state_d;
    logic                r_sync1, r_sync2, r_sync3;
    logic [PERIOD_W-1:0] r_pcnt, r_slot_len, r_scnt, r_rev_period;
    logic [COL_LOG2:0]   r_emitted;
    logic [COL_LOG2-1:0] r_column_idx;
    logic                r_write_data, r_short_rev;

    logic                w_idx_edge, w_accept, w_timeout, w_slot_exp, w_latch;
    logic [PERIOD_W-1:0] w_period, w_scnt_d;
    logic [COL_LOG2:0]   w_emitted_d;
    logic [COL_LOG2-1:0] w_column_d;
    logic                w_write_d, w_short_d;

    assign w_idx_edge = r_sync2 & ~r_sync3;
    assign w_accept   = w_idx_edge && ((r_state == StIdle) || (r_pcnt >= MinPeriod));
    assign w_timeout  = (r_pcnt == PcntMax);
    // pcnt restarts at 0 on the accepting cycle, so the elapsed length is pcnt + 1
    assign w_period   = w_timeout ? PcntMax : r_pcnt + PERIOD_W'(1);
    assign w_slot_exp = (r_scnt == r_slot_len - PERIOD_W'(1)) && (r_emitted < EmitFull);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_accept) begin
            w_state_d = (r_state == StIdle) ? StAcquire : StRun;
        end else if (w_timeout) begin
            w_state_d = StIdle;
        end
    end

    always_comb begin
        w_write_d   = 1'b0;
        w_short_d   = 1'b0;
        w_latch     = 1'b0;
        w_column_d  = r_column_idx;
        w_scnt_d    = r_scnt;
        w_emitted_d = r_emitted;
        unique case (r_state)
            StIdle: begin
                w_column_d = '0;
            end
            StAcquire, StRun: begin
                if (w_accept) begin
                    w_latch     = 1'b1;
                    w_write_d   = 1'b1;
                    w_short_d   = (r_state == StRun) && (r_emitted < EmitFull);
                    w_column_d  = '0;
                    w_scnt_d    = '0;
                    w_emitted_d = (COL_LOG2 + 1)'(1);
                end else if (w_timeout) begin
                    w_column_d = '0;
                end else if (r_state == StRun) begin
                    if (w_slot_exp) begin
                        w_write_d   = 1'b1;
                        w_column_d  = r_column_idx + COL_LOG2'(1);
                        w_emitted_d = r_emitted + (COL_LOG2 + 1)'(1);
                        w_scnt_d    = '0;
                    end else begin
                        w_scnt_d = r_scnt + PERIOD_W'(1);
                    end
                end
            end
            default: begin
                w_column_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_pcnt       <= '0;
            r_slot_len   <= '0;
            r_scnt       <= '0;
            r_rev_period <= '0;
            r_emitted    <= '0;
            r_column_idx <= '0;
            r_write_data <= 1'b0;
            r_short_rev  <= 1'b0;
        end else begin
            r_sync1      <= bus.index_in;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            if (w_accept) begin
                r_pcnt <= '0;
            end else if (!w_timeout) begin
                r_pcnt <= r_pcnt + PERIOD_W'(1);
            end
            if (w_latch) begin
                r_rev_period <= w_period;
                r_slot_len   <= w_period >> COL_LOG2;
            end
            r_scnt       <= w_scnt_d;
            r_emitted    <= w_emitted_d;
            r_column_idx <= w_column_d;
            r_write_data <= w_write_d;
            r_short_rev  <= w_short_d;
        end
    end

    assign bus.write_data   = r_write_data;
    assign bus.column_idx   = r_column_idx;
    assign bus.rev_period   = r_rev_period;
    assign bus.period_valid = (r_state == StRun);
    assign bus.short_rev    = r_short_rev;
endmodule

// File: tb/tb_pov_column_timer.sv
// Scoreboard bench for pov_column_timer: stimulus queues expected strobes, a monitor
// pops and compares them whenever write_data is seen.
module tb_pov_column_timer;
    typedef struct {
        int cyc;
        int col;
        bit shrt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    pov_column_timer_if #(.COL_LOG2(2), .PERIOD_W(12)) bus ();

    pov_column_timer #(
        .COL_LOG2  (2),
        .PERIOD_W  (12),
        .MIN_PERIOD(8)
    ) dut (
        .sys_clk(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic push(input int c, input int col, input bit s);
        exp_t x;
        x.cyc  = c;
        x.col  = col;
        x.shrt = s;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse(input int w);
        bus.index_in = 1'b1;
        repeat (w) tick();
        bus.index_in = 1'b0;
    endtask

    // Monitor: cycle n is sampled 1 time unit after the n-th rising edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe: col %0d due at cyc %0d, got none", q[0].col, q[0].cyc);
            void'(q.pop_front());
        end
        if (bus.write_data) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe @cyc %0d: got col %0d, want no strobe",
                         cyc, bus.column_idx);
            end else begin
                e = q.pop_front();
                chk("strobe_cyc", cyc, e.cyc);
                chk("strobe_col", int'(bus.column_idx), e.col);
                chk("strobe_short_rev", int'(bus.short_rev), int'(e.shrt));
            end
        end else if (bus.short_rev) begin
            checks++;
            errors++;
            $display("FAIL lone_short_rev @cyc %0d: got 1, want 0", cyc);
        end
    end

    initial begin
        int a, b, c, d, ee, f, g;
        bus.index_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_write_data", int'(bus.write_data), 0);
        chk("rst_column_idx", int'(bus.column_idx), 0);
        chk("rst_rev_period", int'(bus.rev_period), 0);
        chk("rst_period_valid", int'(bus.period_valid), 0);
        chk("rst_short_rev", int'(bus.short_rev), 0);
        rst_n = 1'b1;

        // 1: 400-cycle rotation, strobe 3 cycles after the second pin edge
        a = 10;
        push(a + 403, 0, 0);
        push(a + 503, 1, 0);
        push(a + 603, 2, 0);
        push(a + 703, 3, 0);
        run_to(a);
        pulse(2);
        run_to(a + 400);
        pulse(2);
        run_to(a + 404);
        chk("t1_rev_period", int'(bus.rev_period), 400);
        chk("t1_period_valid", int'(bus.period_valid), 1);

        // 2: short revolution; edge and column-2 expiry coincide, edge wins
        b = a + 800;
        push(b + 3, 0, 0);
        push(b + 103, 1, 0);
        push(b + 203, 0, 1);
        run_to(b);
        pulse(2);
        run_to(b + 200);
        pulse(2);
        run_to(b + 204);
        chk("t2_rev_period", int'(bus.rev_period), 200);

        // 3: 2-cycle glitch 5 cycles after an accepted edge
        c = b + 200;
        push(c + 53, 1, 0);
        push(c + 103, 2, 0);
        push(c + 153, 3, 0);
        push(c + 203, 0, 0);
        run_to(c + 5);
        pulse(2);
        run_to(c + 100);
        chk("t3_rev_period_mid", int'(bus.rev_period), 200);
        run_to(c + 200);
        pulse(2);
        run_to(c + 204);
        chk("t3_rev_period", int'(bus.rev_period), 200);

        // 5: edge lands on the column-3 expiry
        d = c + 200;
        push(d + 53, 1, 0);
        push(d + 103, 2, 0);
        push(d + 153, 0, 1);
        run_to(d + 150);
        pulse(2);
        run_to(d + 154);
        chk("t5_rev_period", int'(bus.rev_period), 150);

        // 4: index stops; slot_len 37, then timeout at pcnt=4095
        ee = d + 150;
        push(ee + 40, 1, 0);
        push(ee + 77, 2, 0);
        push(ee + 114, 3, 0);
        run_to(ee + 4098);
        chk("t4_valid_before_timeout", int'(bus.period_valid), 1);
        run_to(ee + 4099);
        chk("t4_valid_after_timeout", int'(bus.period_valid), 0);
        chk("t4_rev_period_kept", int'(bus.rev_period), 150);
        chk("t4_column_idx", int'(bus.column_idx), 0);

        // 6: reacquire, then reset mid-revolution
        f = ee + 4110;
        run_to(f);
        pulse(2);
        run_to(f + 300);
        push(f + 303, 0, 0);
        push(f + 378, 1, 0);
        pulse(2);
        run_to(f + 400);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_write_data", int'(bus.write_data), 0);
        chk("t6_rst_column_idx", int'(bus.column_idx), 0);
        chk("t6_rst_rev_period", int'(bus.rev_period), 0);
        chk("t6_rst_period_valid", int'(bus.period_valid), 0);
        chk("t6_rst_short_rev", int'(bus.short_rev), 0);
        tick();
        rst_n = 1'b1;
        g = f + 420;
        run_to(g);
        pulse(2);
        run_to(g + 50);
        chk("t6_acquire_valid", int'(bus.period_valid), 0);
        run_to(g + 200);
        push(g + 203, 0, 0);
        pulse(2);
        run_to(g + 210);
        chk("t6_rev_period", int'(bus.rev_period), 200);
        chk("t6_period_valid", int'(bus.period_valid), 1);
        chk("pending_strobes", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
